// File: rtl/hpdcache_sram_arb_pkg.sv
// Shared types and helpers for the 1RW SRAM arbiter.
// Defines the response FSM states, the request bundle and the id width helper.
package hpdcache_sram_arb_pkg;

  // Default geometry; also the widest request bundle the arbiter carries.
  localparam int unsigned SRAM_ARB_ADDR_SIZE = 6;
  localparam int unsigned SRAM_ARB_DATA_SIZE = 64;
  localparam int unsigned SRAM_ARB_BE_SIZE   = SRAM_ARB_DATA_SIZE / 8;

  typedef enum logic [1:0] {
    RSP_IDLE     = 2'd0,
    RSP_RD_PEND  = 2'd1,
    RSP_RD_PEND2 = 2'd2,
    RSP_HOLD     = 2'd3
  } rsp_fsm_e;

  typedef struct packed {
    logic                          we;
    logic [SRAM_ARB_ADDR_SIZE-1:0] addr;
    logic [SRAM_ARB_DATA_SIZE-1:0] wdata;
    logic [SRAM_ARB_BE_SIZE-1:0]   be;
  } sram_arb_req_t;

  function automatic int unsigned sram_arb_id_width(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hpdcache_sram_rr_prio.sv
// Round-robin one-hot selector: first set request at or after ptr_i, wrapping.
// Ports: req_i mask, ptr_i start index; gnt_o one-hot, idx_o index, any_o valid.
module hpdcache_sram_rr_prio #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // First pass covers [ptr, N-1], second pass wraps to [0, ptr-1].
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (i >= 32'(ptr_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = W'(i);
        any_o    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_o && req_i[i]) begin
        gnt_o[i] = 1'b1;
        idx_o    = W'(i);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpdcache_sram_1rw_arbiter.sv
// Round-robin arbiter sharing one 1RW byte-enable SRAM between NREQ requesters.
// Ports: clk_i, rst_i (sync, active-high); req_{valid,we,addr,wdata,be}_i /
//   req_ready_o per requester; rsp_{valid,id,rdata}_o + rsp_ready_i shared read
//   response; sram_{cs,we,addr,wdata,wbyteenable}_o, sram_rdata_i to the macro.
// Build option HPDCACHE_SRAM_ARB_RSP_REG_EN: registered response, latency 2.
module hpdcache_sram_1rw_arbiter
  import hpdcache_sram_arb_pkg::*;
#(
  parameter  int unsigned NREQ      = 2,
  parameter  int unsigned ADDR_SIZE = SRAM_ARB_ADDR_SIZE,
  parameter  int unsigned DATA_SIZE = SRAM_ARB_DATA_SIZE,
  localparam int unsigned IDW       = sram_arb_id_width(NREQ),
  localparam int unsigned BEW       = DATA_SIZE / 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_valid_i,
  output logic [NREQ-1:0]           req_ready_o,
  input  logic [NREQ-1:0]           req_we_i,
  input  logic [NREQ*ADDR_SIZE-1:0] req_addr_i,
  input  logic [NREQ*DATA_SIZE-1:0] req_wdata_i,
  input  logic [NREQ*BEW-1:0]       req_be_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [IDW-1:0]            rsp_id_o,
  output logic [DATA_SIZE-1:0]      rsp_rdata_o,
  output logic                      sram_cs_o,
  output logic                      sram_we_o,
  output logic [ADDR_SIZE-1:0]      sram_addr_o,
  output logic [DATA_SIZE-1:0]      sram_wdata_o,
  output logic [BEW-1:0]            sram_wbyteenable_o,
  input  logic [DATA_SIZE-1:0]      sram_rdata_i
);

  rsp_fsm_e             state_q;
  logic                 rsp_valid_q;
  logic [IDW-1:0]       id_q;
  logic [DATA_SIZE-1:0] rdata_q;
  logic [IDW-1:0]       ptr_q;
  logic [IDW-1:0]       ptr_d;

  logic                 rd_block;
  logic [NREQ-1:0]      elig;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 gnt_any;
  logic                 issue;
  logic                 rd_acc;
  sram_arb_req_t        sel;

  // A read may only issue when its data has a guaranteed path out;
  // otherwise readers are skipped and writers still use the SRAM.
`ifdef HPDCACHE_SRAM_ARB_RSP_REG_EN
  assign rd_block = (state_q == RSP_RD_PEND)
                 || (state_q == RSP_HOLD)
                 || ((state_q == RSP_RD_PEND2) && !rsp_ready_i);
`else
  assign rd_block = (state_q == RSP_HOLD)
                 || ((state_q == RSP_RD_PEND) && !rsp_ready_i);
`endif

  assign elig = req_valid_i & (req_we_i | {NREQ{~rd_block}});

  hpdcache_sram_rr_prio #(
    .N (NREQ),
    .W (IDW)
  ) u_rr (
    .req_i (elig),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign issue       = gnt_any & ~rst_i;
  assign req_ready_o = issue ? gnt : '0;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel.we    = req_we_i[i];
        sel.addr  = SRAM_ARB_ADDR_SIZE'(
                      req_addr_i[i*ADDR_SIZE +: ADDR_SIZE]);
        sel.wdata = SRAM_ARB_DATA_SIZE'(
                      req_wdata_i[i*DATA_SIZE +: DATA_SIZE]);
        sel.be    = SRAM_ARB_BE_SIZE'(req_be_i[i*BEW +: BEW]);
      end
    end
  end

  assign sram_cs_o          = issue;
  assign sram_we_o          = sel.we;
  assign sram_addr_o        = ADDR_SIZE'(sel.addr);
  assign sram_wdata_o       = DATA_SIZE'(sel.wdata);
  assign sram_wbyteenable_o = BEW'(sel.be);

  assign rd_acc = issue & ~sel.we;

  always_comb begin
    ptr_d = ptr_q;
    if (issue) begin
      ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RSP_IDLE;
      rsp_valid_q <= 1'b0;
      id_q        <= '0;
      rdata_q     <= '0;
      ptr_q       <= '0;
    end else begin
      ptr_q <= ptr_d;
      unique case (state_q)
        RSP_IDLE: begin
          if (rd_acc) begin
            state_q <= RSP_RD_PEND;
            id_q    <= gnt_idx;
`ifndef HPDCACHE_SRAM_ARB_RSP_REG_EN
            rsp_valid_q <= 1'b1;
`endif
          end
        end
`ifdef HPDCACHE_SRAM_ARB_RSP_REG_EN
        RSP_RD_PEND: begin
          rdata_q     <= sram_rdata_i;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP_RD_PEND2;
        end
        RSP_RD_PEND2: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            if (rd_acc) begin
              state_q <= RSP_RD_PEND;
              id_q    <= gnt_idx;
            end else begin
              state_q <= RSP_IDLE;
            end
          end else begin
            state_q <= RSP_HOLD;
          end
        end
`else
        RSP_RD_PEND: begin
          if (rsp_ready_i) begin
            if (rd_acc) begin
              id_q <= gnt_idx;
            end else begin
              state_q     <= RSP_IDLE;
              rsp_valid_q <= 1'b0;
            end
          end else begin
            // SRAM output is only valid this cycle; keep a copy.
            rdata_q <= sram_rdata_i;
            state_q <= RSP_HOLD;
          end
        end
`endif
        RSP_HOLD: begin
          if (rsp_ready_i) begin
            state_q     <= RSP_IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= RSP_IDLE;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = id_q;

`ifdef HPDCACHE_SRAM_ARB_RSP_REG_EN
  assign rsp_rdata_o = rdata_q;
`else
  assign rsp_rdata_o = (state_q == RSP_RD_PEND) ? sram_rdata_i : rdata_q;
`endif

endmodule
